// File: rtl/dual_read_fifo_pkg.sv
// Shared core constants and helpers for the dual-read instruction FIFO.
// Entries carry the destination register field Rd in their top bits.
package dual_read_fifo_pkg;

    localparam int DataWidth  = 92;
    localparam int Depth      = 4;
    localparam int RdMsb      = 91;
    localparam int RdLsb      = 86;
    localparam int PtrWidth   = 2;
    localparam int CountWidth = 3;

    typedef logic [PtrWidth-1:0]   ptr_t;
    typedef logic [CountWidth-1:0] count_t;

    // Pointer arithmetic wraps naturally at the 2-bit width.
    function automatic ptr_t ptr_add(input ptr_t base, input ptr_t step);
        return ptr_t'(base + step);
    endfunction

    function automatic logic [RdMsb-RdLsb:0] entry_rd(input logic [DataWidth-1:0] entry);
        return entry[RdMsb:RdLsb];
    endfunction

endpackage

// File: rtl/dual_read_fifo_slot.sv
// One FIFO storage slot. The write and pop requests are broadcast to every
// slot; each slot matches them against its own index MyPtr.
module dual_read_fifo_slot
    import dual_read_fifo_pkg::*;
#(
    parameter int Width = 92,
    parameter int MyPtr = 0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             flush,
    input  logic             write_en,
    input  ptr_t             wr_ptr,
    input  logic [Width-1:0] write_data,
    input  ptr_t             clear_cnt,
    input  ptr_t             rd_ptr,
    output logic [Width-1:0] slot_data
);

    localparam ptr_t MyIdx = ptr_t'(MyPtr);

    logic             write_hit_s;
    logic             clear_hit_s;
    logic [Width-1:0] data_r;

    // Decode whether this slot is written or popped this cycle.
    always_comb begin
        write_hit_s = write_en && (wr_ptr == MyIdx);
        if (clear_cnt == 2'd2) begin
            clear_hit_s = (rd_ptr == MyIdx) || (ptr_add(rd_ptr, 2'd1) == MyIdx);
        end else if (clear_cnt == 2'd1) begin
            clear_hit_s = (rd_ptr == MyIdx);
        end else begin
            clear_hit_s = 1'b0;
        end
    end

    // Slot storage; a write and a clear never address the same slot together.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            data_r <= {Width{1'b0}};
        end else if (flush) begin
            data_r <= {Width{1'b0}};
        end else if (write_hit_s) begin
            data_r <= write_data;
        end else if (clear_hit_s) begin
            data_r <= {Width{1'b0}};
        end else begin
            data_r <= data_r;
        end
    end

    assign slot_data = data_r;

endmodule

// File: rtl/dual_read_fifo.sv
// Four-entry FIFO exposing its two oldest entries, able to pop one or two
// entries and push one entry per cycle. Flush discards everything.
module dual_read_fifo #(
    parameter int DataWidth = dual_read_fifo_pkg::DataWidth,
    parameter int Depth     = dual_read_fifo_pkg::Depth
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 writeEn,
    input  logic [DataWidth-1:0] writeData,
    input  logic                 readEn1,
    input  logic                 readEn2,
    input  logic                 flush,
    output logic [DataWidth-1:0] readData1,
    output logic [DataWidth-1:0] readData2,
    output logic                 valid1,
    output logic                 valid2,
    output logic                 full,
    output logic [2:0]           count
);

    import dual_read_fifo_pkg::*;

    ptr_t   rd_ptr_r;
    ptr_t   wr_ptr_r;
    count_t count_r;
    ptr_t   rd_ptr_nxt_s;
    ptr_t   wr_ptr_nxt_s;
    count_t count_nxt_s;
    ptr_t   pop_cnt_s;
    ptr_t   clear_cnt_s;
    logic   push_s;
    logic   write_en_s;
    logic   valid1_s;
    logic   valid2_s;
    logic   full_s;
    ptr_t   rd_ptr_p1_s;

    logic [DataWidth-1:0] slot_data_s [Depth];

    assign valid1_s    = (count_r != 3'd0);
    assign valid2_s    = (count_r >= 3'd2);
    assign full_s      = (count_r == 3'd4);
    assign rd_ptr_p1_s = ptr_add(rd_ptr_r, 2'd1);

    // Push/pop qualification and next pointer/count state.
    always_comb begin
        push_s = writeEn & ~full_s;
        if (readEn1 && readEn2 && valid2_s) begin
            pop_cnt_s = 2'd2;
        end else if (readEn1 && valid1_s) begin
            pop_cnt_s = 2'd1;
        end else begin
            pop_cnt_s = 2'd0;
        end

        if (flush) begin
            rd_ptr_nxt_s = 2'd0;
            wr_ptr_nxt_s = 2'd0;
            count_nxt_s  = 3'd0;
            write_en_s   = 1'b0;
            clear_cnt_s  = 2'd0;
        end else begin
            rd_ptr_nxt_s = ptr_add(rd_ptr_r, pop_cnt_s);
            wr_ptr_nxt_s = ptr_add(wr_ptr_r, {1'b0, push_s});
            count_nxt_s  = count_t'(count_r + {2'b00, push_s} - {1'b0, pop_cnt_s});
            write_en_s   = push_s;
            clear_cnt_s  = pop_cnt_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rd_ptr_r <= 2'd0;
            wr_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    for (genvar i = 0; i < Depth; i++) begin : g_slot
        dual_read_fifo_slot #(
            .Width (DataWidth),
            .MyPtr (i)
        ) u_slot (
            .clk        (clk),
            .rstN       (rstN),
            .flush      (flush),
            .write_en   (write_en_s),
            .wr_ptr     (wr_ptr_r),
            .write_data (writeData),
            .clear_cnt  (clear_cnt_s),
            .rd_ptr     (rd_ptr_r),
            .slot_data  (slot_data_s[i])
        );
    end

    // Reads come straight from storage, so a push shows up the cycle after.
    assign readData1 = valid1_s ? slot_data_s[rd_ptr_r]    : {DataWidth{1'b0}};
    assign readData2 = valid2_s ? slot_data_s[rd_ptr_p1_s] : {DataWidth{1'b0}};
    assign valid1    = valid1_s;
    assign valid2    = valid2_s;
    assign full      = full_s;
    assign count     = count_r;

endmodule

// File: tb/tb_dual_read_fifo.sv
// Directed self-checking bench for dual_read_fifo: reset, fill, dual pop
// with push, wrap-around, ignored pops, flush and mid-operation reset.
module tb_dual_read_fifo;

    localparam int W = 92;

    logic         clk = 1'b0;
    logic         rstN;
    logic         writeEn;
    logic [W-1:0] writeData;
    logic         readEn1;
    logic         readEn2;
    logic         flush;
    logic [W-1:0] readData1;
    logic [W-1:0] readData2;
    logic         valid1;
    logic         valid2;
    logic         full;
    logic [2:0]   count;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [W-1:0] A1 = {6'd1,  86'h0A1_1111};
    localparam logic [W-1:0] A2 = {6'd2,  86'h0A2_2222};
    localparam logic [W-1:0] A3 = {6'd3,  86'h0A3_3333};
    localparam logic [W-1:0] A4 = {6'd4,  86'h0A4_4444};
    localparam logic [W-1:0] A5 = {6'd5,  86'h0A5_5555};
    localparam logic [W-1:0] B1 = {6'd33, 86'h0B1_0001};
    localparam logic [W-1:0] C1 = {6'd63, 86'h0C1_0C1C};
    localparam logic [W-1:0] C2 = {6'd62, 86'h0C2_0C2C};
    localparam logic [W-1:0] D1 = {6'd11, 86'h0D1_0001};
    localparam logic [W-1:0] D2 = {6'd12, 86'h0D2_0002};
    localparam logic [W-1:0] D3 = {6'd13, 86'h0D3_0003};
    localparam logic [W-1:0] D4 = {6'd14, 86'h0D4_0004};
    localparam logic [W-1:0] E1 = {6'd40, 86'h0E1_0E1E};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] q [$];

    dual_read_fifo dut (
        .clk       (clk),
        .rstN      (rstN),
        .writeEn   (writeEn),
        .writeData (writeData),
        .readEn1   (readEn1),
        .readEn2   (readEn2),
        .flush     (flush),
        .readData1 (readData1),
        .readData2 (readData2),
        .valid1    (valid1),
        .valid2    (valid2),
        .full      (full),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        writeEn = 1'b0; readEn1 = 1'b0; readEn2 = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; idle(); writeEn = 1'b1; writeData = A1;
        tick(); tick();
        rstN = 1'b1; idle();
        tick();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid1: got %b want 0", valid1); end
        vectors++; if (valid2 !== 1'b0) begin miscompares++; $display("FAIL reset_valid2: got %b want 0", valid2); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (readData1 !== ZERO) begin miscompares++; $display("FAIL reset_rd1: got %h want 0", readData1); end
        vectors++; if (readData2 !== ZERO) begin miscompares++; $display("FAIL reset_rd2: got %h want 0", readData2); end
    endtask

    task automatic test_fill();
        logic [W-1:0] a_vec [4];
        a_vec = '{A1, A2, A3, A4};
        for (int i = 0; i < 4; i++) begin
            writeEn = 1'b1; writeData = a_vec[i];
            tick();
            vectors++; if (count !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            vectors++; if (readData1 !== A1) begin miscompares++; $display("FAIL fill_rd1[%0d]: got %h want %h", i, readData1, A1); end
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
        writeEn = 1'b1; writeData = A5;
        tick();
        idle();
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_drop_count: got %0d want 4", count); end
        vectors++; if (readData1 !== A1) begin miscompares++; $display("FAIL fill_drop_rd1: got %h want %h", readData1, A1); end
        vectors++; if (readData2 !== A2) begin miscompares++; $display("FAIL fill_drop_rd2: got %h want %h", readData2, A2); end
    endtask

    task automatic test_dual_pop_push();
        // Pop while full: the same-cycle push must be dropped.
        readEn1 = 1'b1; writeEn = 1'b1; writeData = A5;
        tick();
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL pop1_count: got %0d want 3", count); end
        vectors++; if (readData1 !== A2) begin miscompares++; $display("FAIL pop1_rd1: got %h want %h", readData1, A2); end
        vectors++; if (readData2 !== A3) begin miscompares++; $display("FAIL pop1_rd2: got %h want %h", readData2, A3); end
        readEn1 = 1'b1; readEn2 = 1'b1; writeEn = 1'b1; writeData = B1;
        tick();
        idle();
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL pop2_count: got %0d want 2", count); end
        vectors++; if (readData1 !== A4) begin miscompares++; $display("FAIL pop2_rd1: got %h want %h", readData1, A4); end
        vectors++; if (readData2 !== B1) begin miscompares++; $display("FAIL pop2_rd2: got %h want %h", readData2, B1); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL pop2_full: got %b want 0", full); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] w;
        q = {};
        q.push_back(A4);
        q.push_back(B1);
        for (int i = 0; i < 10; i++) begin
            w = {6'(i + 20), 80'h0000_C0DE_0000_0000_BEEF, 6'(i)};
            writeEn = 1'b1; writeData = w; readEn1 = 1'b1; readEn2 = 1'b0;
            tick();
            void'(q.pop_front());
            q.push_back(w);
            vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL wrap_count[%0d]: got %0d want 2", i, count); end
            vectors++; if (readData1 !== q[0]) begin miscompares++; $display("FAIL wrap_rd1[%0d]: got %h want %h", i, readData1, q[0]); end
            vectors++; if (readData2 !== q[1]) begin miscompares++; $display("FAIL wrap_rd2[%0d]: got %h want %h", i, readData2, q[1]); end
        end
        idle();
    endtask

    task automatic test_ignored_pops();
        readEn2 = 1'b1;
        tick();
        idle();
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL rd2only_count: got %0d want 2", count); end
        vectors++; if (readData1 !== q[0]) begin miscompares++; $display("FAIL rd2only_rd1: got %h want %h", readData1, q[0]); end
        readEn1 = 1'b1;
        tick();
        idle();
        void'(q.pop_front());
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL drain_count: got %0d want 1", count); end
        vectors++; if (readData1 !== q[0]) begin miscompares++; $display("FAIL drain_rd1: got %h want %h", readData1, q[0]); end
    endtask

    task automatic test_single_dual_pop();
        readEn1 = 1'b1; readEn2 = 1'b1;
        vectors++; if (valid2 !== 1'b0) begin miscompares++; $display("FAIL single_valid2_pre: got %b want 0", valid2); end
        tick();
        idle();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL single_count: got %0d want 0", count); end
        vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL single_valid1: got %b want 0", valid1); end
        vectors++; if (valid2 !== 1'b0) begin miscompares++; $display("FAIL single_valid2: got %b want 0", valid2); end
        vectors++; if (readData1 !== ZERO) begin miscompares++; $display("FAIL single_rd1: got %h want 0", readData1); end
        readEn1 = 1'b1;
        tick();
        idle();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL empty_pop_count: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        writeEn = 1'b1;
        writeData = D1; tick();
        writeData = D2; tick();
        writeData = D3; tick();
        idle();
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush = 1'b1; writeEn = 1'b1; writeData = D4; readEn1 = 1'b1;
        tick();
        idle();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", count); end
        vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL flush_valid1: got %b want 0", valid1); end
        vectors++; if (readData1 !== ZERO) begin miscompares++; $display("FAIL flush_rd1: got %h want 0", readData1); end
        writeEn = 1'b1; writeData = C1;
        tick();
        idle();
        vectors++; if (readData1 !== C1) begin miscompares++; $display("FAIL flush_push_rd1: got %h want %h", readData1, C1); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL flush_push_count: got %0d want 1", count); end
        vectors++; if (readData2 !== ZERO) begin miscompares++; $display("FAIL flush_push_rd2: got %h want 0", readData2); end
    endtask

    task automatic test_reset_mid();
        rstN = 1'b0; writeEn = 1'b1; writeData = C2; readEn1 = 1'b1;
        tick();
        rstN = 1'b1; idle();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL midrst_count: got %0d want 0", count); end
        vectors++; if (readData1 !== ZERO) begin miscompares++; $display("FAIL midrst_rd1: got %h want 0", readData1); end
        writeEn = 1'b1; writeData = E1;
        tick();
        idle();
        vectors++; if (readData1 !== E1) begin miscompares++; $display("FAIL midrst_push_rd1: got %h want %h", readData1, E1); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL midrst_push_count: got %0d want 1", count); end
    endtask

    initial begin
        rstN = 1'b0;
        writeData = ZERO;
        idle();
        test_reset();
        test_fill();
        test_dual_pop_push();
        test_wrap();
        test_ignored_pops();
        test_single_dual_pop();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dual_read_fifo.md
DUAL_READ_FIFO -- requirements
Module: dual_read_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 92, entry width in bits.
REQ-002 SHALL have parameter Depth, default 4, entry count; only 4 is supported.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rstN  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port writeEn  input  1  push request, one entry per cycle.
REQ-006 SHALL have port writeData  input  DataWidth  push payload; bits [91:86] hold Rd.
REQ-007 SHALL have port readEn1  input  1  pop the oldest entry.
REQ-008 SHALL have port readEn2  input  1  pop the second-oldest entry; meaningful only with readEn1.
REQ-009 SHALL have port flush  input  1  discard all entries (mispredict).
REQ-010 SHALL have port readData1  output  DataWidth  oldest entry, or zero when valid1 is low.
REQ-011 SHALL have port readData2  output  DataWidth  second-oldest entry, or zero when valid2 is low.
REQ-012 SHALL have port valid1  output  1  count >= 1.
REQ-013 SHALL have port valid2  output  1  count >= 2.
REQ-014 SHALL have port full  output  1  count == 4.
REQ-015 SHALL have port count  output  3  registered occupancy, 0..4.

Function
REQ-016 SHALL keep a 2-bit rdPtr, a 2-bit wrPtr and a 3-bit count; both pointers wrap modulo 4.
REQ-017 SHALL derive valid1, valid2 and full combinationally from registered count only.
REQ-018 SHALL drive readData1 from the slot at rdPtr and readData2 from the slot at rdPtr+1 (mod 4), gated to zero when not valid.
REQ-019 SHALL accept a push when writeEn & ~full: write slot wrPtr, then wrPtr+1.
REQ-020 SHALL ignore writeEn when full, even if a pop occurs in the same cycle (no pass-through).
REQ-021 SHALL set pop count to 2 if readEn1 & readEn2 & valid2; to 1 if readEn1 & valid1; otherwise to 0.
REQ-022 SHALL ignore readEn2 without readEn1, and ignore readEn1 when empty.
REQ-023 SHALL zero each popped slot and advance rdPtr by the pop count.
REQ-024 SHALL update next count as count + push - pop; simultaneous push and pop are legal, for example 2 + 1 - 2 = 1.
REQ-025 SHALL make a pushed entry visible on the read ports one cycle after the push, with no write-to-read bypass.
REQ-026 SHALL, on flush, clear all slots, set rdPtr, wrPtr and count to 0, and drop any same-cycle push or pop.
REQ-027 SHALL give priority in this order: rstN, then flush, then push/pop.
REQ-028 SHALL, when a push writes slot wrPtr and a pop zeroes a different slot in the same cycle, apply both; the two can never target the same slot.

Reset
REQ-029 SHALL, while rstN is low at a clock edge, set rdPtr=0, wrPtr=0, count=0 and all slots to zero.
REQ-030 SHALL hold outputs after reset at valid1=0, valid2=0, full=0, count=0, readData1=0, readData2=0.
REQ-031 SHALL, on reset mid-operation, discard all entries, and any push or pop in that cycle has no effect.

Structure
REQ-032 SHALL take DataWidth (92), Depth (4), RdMsb (91) and RdLsb (86) from the shared core package.
REQ-033 SHALL implement each storage slot as sub-module dual_read_fifo_slot, with parameter MyPtr and inputs write-hit, clear-hit and flush.
REQ-034 SHALL compute the pointer, count and pop logic in a single always_comb block, and the registers in a single always_ff block.

Verification
REQ-035 SHALL test reset: hold rstN low for 2 cycles, then release -> count=0, valid1=0, readData1=0.
REQ-036 SHALL test fill to full: push A1..A4 on 4 consecutive cycles -> full=1, count=4; a 5th push of A5 is dropped; readData1=A1, readData2=A2.
REQ-037 SHALL test a dual pop with a push in the same cycle: start from {A1..A4}, pop 1 entry (count 3), then assert readEn1 & readEn2 with a push of B1 -> count=2, readData1=A4, readData2=B1.
REQ-038 SHALL test pointer wrap-around: run 10 push/pop cycles with 1 push and 1 pop per cycle -> FIFO order is preserved, count stays constant, rdPtr wraps 3 to 0.
REQ-039 SHALL test single-entry dual pop: with count=1, assert readEn1 & readEn2 -> only 1 entry is popped, count=0, valid2 stays 0 throughout.
REQ-040 SHALL test flush with a push: with count=3, assert flush together with writeEn -> next cycle count=0, valid1=0, the pushed data is absent, and a following push C1 appears on readData1.
